// File: rtl/pkt_gen_ctrl_pkg.sv
// pkt_gen_ctrl_pkg: shared state encoding and default width for the packet generator.
`default_nettype none

package pkt_gen_ctrl_pkg;

  localparam int PKTGEN_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } pktgen_state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_gen_ctrl.sv
// ============================================================================
// Module   : pkt_gen_ctrl
// Purpose  : Packet-generator sequencer driving an Avalon-ST source (ready
//            latency 0) from shadowed NUMPKTS/PKTLENGTH/PAYLOAD settings.
// Options  : PKTGEN_INCR_PAYLOAD_EN -- data = payload + beat index when defined,
//            constant payload otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_gen_ctrl
  import pkt_gen_ctrl_pkg::*;
#(
  parameter int DATA_W = PKTGEN_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cfg_numpkts,
  input  logic [DATA_W-1:0] cfg_pktlength,
  input  logic [DATA_W-1:0] cfg_payload,
  input  logic              start_req,
  input  logic              stop_req,
  input  logic              src_ready,
  output logic              src_valid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_sop,
  output logic              src_eop,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pkts_sent
);

  pktgen_state_e     state_q, state_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic [DATA_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] pkts_q, pkts_d;
  logic              stop_q, stop_d;

  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              w_accept;
  logic              w_last;

  assign w_accept = valid_q & src_ready;
  assign w_last   = (beat_q == len_q - DATA_W'(1));

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    len_d   = len_q;
    pay_d   = pay_q;
    beat_d  = beat_q;
    pkts_d  = pkts_q;
    stop_d  = stop_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req && (cfg_pktlength != '0)) begin
          state_d = SEND;
          num_d   = cfg_numpkts;
          len_d   = cfg_pktlength;
          pay_d   = cfg_payload;
          beat_d  = '0;
          pkts_d  = '0;
          stop_d  = 1'b0;
        end
      end
      SEND: begin
        if (stop_req) stop_d = 1'b1;
        if (w_accept) begin
          if (w_last) begin
            pkts_d = pkts_q + DATA_W'(1);
            beat_d = '0;
            // A stop strobe landing on the eop accept still ends the run here.
            if (stop_req || stop_q || ((num_q != '0) && (pkts_d == num_q))) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + DATA_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so every port comes straight off a flop.
    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND);
    sop_d   = valid_d && (beat_d == '0);
    eop_d   = valid_d && (beat_d == len_d - DATA_W'(1));
`ifdef PKTGEN_INCR_PAYLOAD_EN
    data_d  = valid_d ? (pay_d + beat_d) : '0;
`else
    data_d  = valid_d ? pay_d : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      beat_q  <= '0;
      pkts_q  <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      beat_q  <= beat_d;
      pkts_q  <= pkts_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign src_valid = valid_q;
  assign src_data  = data_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pkts_sent = pkts_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_gen_ctrl.sv
// tb_pkt_gen_ctrl: directed scoreboard bench for pkt_gen_ctrl.
`default_nettype none

module tb_pkt_gen_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cfg_numpkts = '0;
  logic [7:0] cfg_pktlength = '0;
  logic [7:0] cfg_payload = '0;
  logic       start_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       src_ready = 1'b1;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_sop;
  logic       src_eop;
  logic       busy;
  logic       done;
  logic [7:0] pkts_sent;

  pkt_gen_ctrl #(.DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_numpkts   (cfg_numpkts),
    .cfg_pktlength (cfg_pktlength),
    .cfg_payload   (cfg_payload),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .src_ready     (src_ready),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
    .busy          (busy),
    .done          (done),
    .pkts_sent     (pkts_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [7:0] p, input int b);
`ifdef PKTGEN_INCR_PAYLOAD_EN
    return p + 8'(b);
`else
    return p;
`endif
  endfunction

  // Queue npkts packets of len beats each.
  task automatic push_run(input int npkts, input int len, input logic [7:0] pay);
    beat_t bt;
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < len; b++) begin
        bt.d   = exp_data(pay, b);
        bt.sop = (b == 0);
        bt.eop = (b == len - 1);
        sb_q.push_back(bt);
      end
    end
  endtask

  // Monitor: pops one expected beat per accepted beat, checks stall hold.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sop, prev_eop;
  always @(negedge clk) begin
    beat_t e;
    if (!reset && prev_stall) begin
      chk("hold_valid", 32'(src_valid), 32'(1));
      chk("hold_data", 32'(src_data), 32'(prev_data));
      chk("hold_sop", 32'(src_sop), 32'(prev_sop));
      chk("hold_eop", 32'(src_eop), 32'(prev_eop));
    end
    if (src_valid && src_ready) begin
      chk("beat_expected", 32'(sb_q.size() > 0), 32'(1));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("beat_data", 32'(src_data), 32'(e.d));
        chk("beat_sop", 32'(src_sop), 32'(e.sop));
        chk("beat_eop", 32'(src_eop), 32'(e.eop));
      end
    end
    prev_stall = src_valid && !src_ready && !reset;
    prev_data  = src_data;
    prev_sop   = src_sop;
    prev_eop   = src_eop;
  end

  task automatic set_cfg(input logic [7:0] n, input logic [7:0] l, input logic [7:0] p);
    cfg_numpkts   = n;
    cfg_pktlength = l;
    cfg_payload   = p;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [7:0] exp_pkts, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'(1));
    chk({tag, "_busy_low"}, 32'(busy), 32'(0));
    chk({tag, "_valid_low"}, 32'(src_valid), 32'(0));
    chk({tag, "_pkts_sent"}, 32'(pkts_sent), 32'(exp_pkts));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(src_valid), 32'(0));
    chk("rst_data", 32'(src_data), 32'(0));
    chk("rst_sop", 32'(src_sop), 32'(0));
    chk("rst_eop", 32'(src_eop), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pkts", 32'(pkts_sent), 32'(0));
    reset = 1'b0;

    // Two packets of three beats, full throughput
    set_cfg(8'd2, 8'd3, 8'h10);
    push_run(2, 3, 8'h10);
    pulse_start();
    chk("t1_start_valid", 32'(src_valid), 32'(1));
    chk("t1_start_sop", 32'(src_sop), 32'(1));
    chk("t1_start_busy", 32'(busy), 32'(1));
    wait_done(40, 8'd2, "t1");

    // Single packet with toggling ready
    set_cfg(8'd1, 8'd4, 8'h10);
    push_run(1, 4, 8'h10);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1 src_ready = ~src_ready;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("t2_done_seen", 32'(seen), 32'(1));
    chk("t2_pkts_sent", 32'(pkts_sent), 32'(1));
    chk("t2_sb_empty", 32'(sb_q.size()), 32'(0));
    @(posedge clk); #1 src_ready = 1'b1;

    // Continuous one-beat packets, counter wraps, stop ends the run
    set_cfg(8'd0, 8'd1, 8'hFE);
    push_run(260, 1, 8'hFE);
    pulse_start();
    repeat (259) @(posedge clk);
    #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    wait_done(10, 8'd4, "t3");

    // Stop on beat 0 of packet 5 of 10 completes that packet
    set_cfg(8'd10, 8'd3, 8'h22);
    push_run(5, 3, 8'h22);
    pulse_start();
    repeat (12) @(posedge clk);
    #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    wait_done(20, 8'd5, "t4");

    // Zero-length start is ignored
    set_cfg(8'd3, 8'd0, 8'h55);
    pulse_start();
    chk("t5_len0_valid", 32'(src_valid), 32'(0));
    chk("t5_len0_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("t5_len0_busy2", 32'(busy), 32'(0));

    // Start during SEND with new config leaves run unchanged
    set_cfg(8'd2, 8'd2, 8'h30);
    push_run(2, 2, 8'h30);
    pulse_start();
    set_cfg(8'd5, 8'd7, 8'h99);
    start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    wait_done(30, 8'd2, "t5");

    // Reset mid-packet, then a fresh run
    set_cfg(8'd1, 8'd4, 8'h70);
    push_run(1, 3, 8'h70);
    sb_q[2].eop = 1'b0;
    pulse_start();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", 32'(src_valid), 32'(0));
    chk("t6_rst_sop", 32'(src_sop), 32'(0));
    chk("t6_rst_eop", 32'(src_eop), 32'(0));
    chk("t6_rst_data", 32'(src_data), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_pkts", 32'(pkts_sent), 32'(0));
    chk("t6_sb_empty", 32'(sb_q.size()), 32'(0));
    reset = 1'b0;
    set_cfg(8'd1, 8'd2, 8'h40);
    push_run(1, 2, 8'h40);
    pulse_start();
    chk("t6_fresh_sop", 32'(src_sop), 32'(1));
    wait_done(20, 8'd1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pkt_gen_ctrl.md
# pkt_gen_ctrl

Packet-generator sequencer for the Avalon register block. It consumes the NUMPKTS, PKTLENGTH and PAYLOAD register values plus start/stop write strobes. It emits a stream of fixed-length packets on an Avalon-ST source (ready latency 0). It also reports busy, a completion pulse and a sent-packet count back to the register block.

## Interface
- DATA_W, 8, stream data width and width of every config/count field
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_numpkts  in  DATA_W  packets per run; 0 = continuous until stop
- cfg_pktlength  in  DATA_W  beats per packet; 0 = invalid
- cfg_payload  in  DATA_W  first data byte of every packet
- start_req  in  1  one-cycle strobe on host write to START
- stop_req  in  1  one-cycle strobe on host write to STOP
- src_ready  in  1  sink ready
- src_valid  out  1  beat valid
- src_data  out  DATA_W  beat data
- src_sop  out  1  first beat of packet
- src_eop  out  1  last beat of packet
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pkts_sent  out  DATA_W  packets completed in current/last run

## Operation
- States: IDLE, SEND.
- IDLE:
  - start_req with cfg_pktlength != 0: latch numpkts/pktlength/payload into shadow registers; clear pkts_sent, beat and stop_pending; go SEND.
  - start_req with cfg_pktlength == 0: ignored.
  - stop_req: ignored.
- SEND:
  - src_valid = 1.
  - Beat accepted when src_valid & src_ready.
  - Beat index b runs 0..len-1.
  - src_sop = (b == 0); src_eop = (b == len-1). Both high together when len = 1.
- On eop accept:
  - pkts_sent += 1, modulo 2^DATA_W.
  - b resets to 0.
  - If stop_pending, or numpkts != 0 and pkts_sent+1 == numpkts: go IDLE and pulse done. Otherwise the next packet starts on the following cycle with no gap.
- stop_req in SEND sets stop_pending. A packet is never truncated; stop takes effect at the next eop accept.
  - stop_req coincident with an eop accept ends the run at that eop.
- start_req in SEND: ignored. Shadow config is unaffected by register writes mid-run.
- Unaccepted beat (src_ready = 0): src_data/sop/eop held stable and src_valid stays high.
- Continuous mode (numpkts = 0): runs until stop; pkts_sent wraps 255 -> 0 without stopping.

## Timing
- Reset values: src_valid=0, src_data=0, src_sop=0, src_eop=0, busy=0, done=0, pkts_sent=0; state IDLE; stop_pending=0.
- Reset mid-run aborts at the next edge; no eop is emitted for the partial packet.
- Start latency: start_req sampled at edge N -> src_valid, src_sop high after edge N; busy high the same cycle.
- Throughput: one beat per cycle while src_ready = 1.
- End of run: final eop accepted at edge M -> done = 1 and busy = 0 for the cycle after M; src_valid = 0 from that cycle.
- A start_req in the done cycle is accepted (state is IDLE).
- All outputs are registered.

## Configuration
- PKTGEN_INCR_PAYLOAD_EN defined: src_data = shadow_payload + b, modulo 2^DATA_W. Wraps 0xFF -> 0x00 within a packet.
- PKTGEN_INCR_PAYLOAD_EN undefined: src_data = shadow_payload on every beat.
- Control, handshake and counts are identical in both builds.

## Structure
- Shared package holds:
  - typedef enum pktgen_state_e {IDLE, SEND}
  - localparam PKTGEN_DATA_W = 8, used as the DATA_W default
- Single module, no sub-module. Beat and packet counters are simple registers inside it.

## Test plan
- numpkts=2, pktlength=3, payload=0x10, ready=1, INCR build -> beats 10,11,12 | 10,11,12; sop on beats 0 and 3, eop on beats 2 and 5; done 1 cycle after beat 5; pkts_sent=2.
- numpkts=1, pktlength=4, ready toggling 1,0 -> each beat held while ready=0; exactly 4 accepted beats; data constant 0x10 in non-INCR build.
- numpkts=0, pktlength=1, payload=0xFE, INCR build -> every beat has sop=eop=1 and data 0xFE; stop_req mid-stream -> run ends after the current beat accepts; done pulses.
- pktlength=3, stop_req on beat 0 of packet 5 of 10 -> beats 1 and 2 still sent; pkts_sent=5; busy falls with done.
- start_req with pktlength=0 -> no valid, busy stays 0. start_req during SEND with new config -> current run unchanged.
- reset asserted mid-packet -> all outputs 0 after the edge; a fresh start produces sop on its first beat.
